// File: rtl/div_chan_sched.sv
// div_chan_sched
//   Round-robin scheduler that shares one serial divider (quotient + weight
//   combine) among NCH delay channels. One requester is granted at a time. Its
//   operands are latched, the divider enable protocol is sequenced
//   (load low, calc high, flush low, commit high), and the 16-bit result is
//   returned tagged with the channel number.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req[NCH]                   per-channel level request
//   dividend_in/divisor_in     29 bits per channel, packed at [29*i +: 29]
//   weight_in                  16 bits per channel, packed at [16*i +: 16]
//   ack[NCH]                   one-cycle pulse when a channel's operands are captured
//   res_valid/res_ch/res_data  one-cycle result strobe; channel and data are held
//   busy                       high whenever the scheduler is not idle
//   div_dividend/div_divisor/div_weight/div_enable   to the divider
//   div_result                 from the divider
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; grant taken on the way out
// LOAD    | operands driven, enable low for LOAD_CYC cycles
// CALC    | enable high for CALC_CYC cycles (iterative divide)
// FLUSH   | enable low for one cycle to rearm the divider counter
// COMMIT  | enable high for one cycle; divider publishes its result
// DONE    | result strobed out, pointer advanced past the served channel
module div_chan_sched #(
    parameter int NCH      = 4,
    parameter int LOAD_CYC = 2,
    parameter int CALC_CYC = 33
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       req,
    input  logic [29*NCH-1:0]    dividend_in,
    input  logic [29*NCH-1:0]    divisor_in,
    input  logic [16*NCH-1:0]    weight_in,
    output logic [NCH-1:0]       ack,
    output logic                 res_valid,
    output logic [1:0]           res_ch,
    output logic [15:0]          res_data,
    output logic                 busy,
    output logic [28:0]          div_dividend,
    output logic [28:0]          div_divisor,
    output logic [15:0]          div_weight,
    output logic                 div_enable,
    input  logic [15:0]          div_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CALC, S_FLUSH, S_COMMIT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [28:0]    dvd_q, dvd_d;
    logic [28:0]    dvs_q, dvs_d;
    logic [15:0]    wgt_q, wgt_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic           en_q, en_d;
    logic           res_valid_q, res_valid_d;
    logic [1:0]     res_ch_q, res_ch_d;
    logic [15:0]    res_data_q, res_data_d;

    logic           sel_found;
    logic [1:0]     sel_idx;
    logic [1:0]     cand;

    // First asserted request scanning from the round-robin pointer upward.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = ptr_q + 2'(k);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        wgt_d       = wgt_q;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        ack_d       = '0;
        en_d        = 1'b0;
        res_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d   = sel_idx;
                    dvd_d   = dividend_in[sel_idx*29 +: 29];
                    dvs_d   = divisor_in[sel_idx*29 +: 29];
                    wgt_d   = weight_in[sel_idx*16 +: 16];
                    ack_d   = NCH'(1) << sel_idx;
                    cnt_d   = 6'(LOAD_CYC - 1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == '0) begin
                    cnt_d   = 6'(CALC_CYC - 1);
                    en_d    = 1'b1;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    state_d = S_FLUSH;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_FLUSH: begin
                en_d    = 1'b1;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                res_valid_d = 1'b1;
                res_ch_d    = gnt_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                res_data_d = div_result;
                ptr_d      = gnt_q + 2'd1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            wgt_q       <= '0;
            ack_q       <= '0;
            en_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            wgt_q       <= wgt_d;
            ack_q       <= ack_d;
            en_q        <= en_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
        end
    end

    // The divider's result appears during DONE, so it is passed straight
    // through while res_valid is high and held from the register afterwards.
    assign res_data     = res_valid_q ? div_result : res_data_q;
    assign res_valid    = res_valid_q;
    assign res_ch       = res_ch_q;
    assign ack          = ack_q;
    assign busy         = (state_q != S_IDLE);
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign div_weight   = wgt_q;
    assign div_enable   = en_q;

endmodule
